// File: rtl/pipeline_dump_pkg.sv
// Shared constants and state encodings for the pipeline state dump block.
// Optional framing (header + checksum states) is enabled by PIPELINE_DUMP_FRAMING_EN.
package pipeline_dump_pkg;

    localparam logic [7:0]  DUMP_HDR           = 8'hA5;
    localparam int unsigned NUM_REGS           = 32;
    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned DEF_BYTES_PER_WORD = 4;

    // Number of bytes in a word of the given bit width.
    function automatic int unsigned bytes_per_word(input int unsigned width);
        return width / BYTE_W;
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD_PC  = 4'd1,
        ST_SEND     = 4'd2,
        ST_RD_REG   = 4'd3,
        ST_WAIT_REG = 4'd4,
        ST_RD_MEM   = 4'd5,
        ST_WAIT_MEM = 4'd6,
        ST_DONE     = 4'd7
`ifdef PIPELINE_DUMP_FRAMING_EN
        ,
        ST_HDR      = 4'd8,
        ST_CSUM     = 4'd9
`endif
    } dump_state_e;

    typedef enum logic [1:0] {
        SRC_PC  = 2'd0,
        SRC_REG = 2'd1,
        SRC_MEM = 2'd2
    } dump_src_e;

endpackage

// File: rtl/pipeline_dump_word_serializer.sv
// Loads one word and emits it LSB byte first over a valid/ready handshake.
// last_c_o flags the edge on which the final byte of the word is accepted.
module dump_word_serializer
    import pipeline_dump_pkg::*;
#(
    parameter int unsigned DATA_SZ = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               one_byte_i,
    input  logic [DATA_SZ-1:0] word_i,
    input  logic               ready_i,
    output logic [7:0]         byte_o,
    output logic               valid_o,
    output logic               last_c_o
);

    localparam int unsigned BPW   = bytes_per_word(DATA_SZ);
    localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

    logic [DATA_SZ-1:0] shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               valid_q;
    logic               one_q;

    assign byte_o   = shift_q[7:0];
    assign valid_o  = valid_q;
    assign last_c_o = valid_q & ready_i & (one_q | (cnt_q == LAST_CNT));

    // Shift register, byte counter and valid flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            one_q   <= 1'b0;
        end else if (load_i) begin
            shift_q <= word_i;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            one_q   <= one_byte_i;
        end else if (valid_q && ready_i) begin
            shift_q <= shift_q >> 8;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_c_o) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipeline_dump.sv
// Dumps PC, register file and the first MEM_WORDS data-memory words as a
// byte stream after the pipeline halts. Define PIPELINE_DUMP_FRAMING_EN to
// wrap the payload in a 0xA5 header byte and a trailing XOR checksum byte.
module pipeline_dump
    import pipeline_dump_pkg::*;
#(
    parameter int unsigned DATA_SZ   = 32,
    parameter int unsigned REG_SZ    = 5,
    parameter int unsigned MEM_SZ    = 10,
    parameter int unsigned MEM_WORDS = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_halt,
    input  logic [DATA_SZ-1:0] i_pc,
    output logic [REG_SZ-1:0]  o_reg_addr,
    input  logic [DATA_SZ-1:0] i_reg_data,
    output logic [MEM_SZ-1:0]  o_mem_addr,
    output logic               o_mem_rd,
    input  logic [DATA_SZ-1:0] i_mem_data,
    output logic [7:0]         o_tx_byte,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [REG_SZ-1:0] LAST_REG = REG_SZ'(NUM_REGS - 1);
    localparam logic [MEM_SZ-1:0] LAST_MEM = MEM_SZ'(MEM_WORDS - 1);

    dump_state_e        state_q;
    dump_src_e          src_q;
    logic               halt_q;
    logic [REG_SZ-1:0]  reg_addr_q;
    logic [MEM_SZ-1:0]  mem_addr_q;
    logic               mem_rd_q;
    logic               busy_q;
    logic               done_q;
`ifdef PIPELINE_DUMP_FRAMING_EN
    logic [7:0]         csum_q;
`endif

    logic               start_c;
    logic               ser_load_c;
    logic               ser_one_c;
    logic [DATA_SZ-1:0] ser_word_c;
    logic               ser_last_c;
    logic [7:0]         tx_byte;
    logic               tx_valid;

    assign start_c    = i_halt & ~halt_q;
    assign o_reg_addr = reg_addr_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_rd   = mem_rd_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_tx_byte  = tx_byte;
    assign o_tx_valid = tx_valid;

    // Select which word (and how many bytes of it) the serializer loads.
    always_comb begin
        ser_load_c = 1'b0;
        ser_one_c  = 1'b0;
        ser_word_c = '0;
        case (state_q)
            ST_LOAD_PC: begin
                ser_load_c = 1'b1;
                ser_word_c = i_pc;
            end
            ST_WAIT_REG: begin
                ser_load_c = 1'b1;
                ser_word_c = i_reg_data;
            end
            ST_WAIT_MEM: begin
                ser_load_c = 1'b1;
                ser_word_c = i_mem_data;
            end
`ifdef PIPELINE_DUMP_FRAMING_EN
            ST_IDLE: begin
                if (start_c) begin
                    ser_load_c = 1'b1;
                    ser_one_c  = 1'b1;
                    ser_word_c = DATA_SZ'(DUMP_HDR);
                end
            end
            ST_SEND: begin
                if (ser_last_c && src_q == SRC_MEM && mem_addr_q == LAST_MEM) begin
                    ser_load_c = 1'b1;
                    ser_one_c  = 1'b1;
                    ser_word_c = DATA_SZ'(csum_q ^ tx_byte);
                end
            end
`endif
            default: ;
        endcase
    end

    // Dump sequencer: walks PC, registers, then memory, with registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_PC;
            halt_q     <= 1'b0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PIPELINE_DUMP_FRAMING_EN
            csum_q     <= '0;
`endif
        end else begin
            halt_q <= i_halt;
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        busy_q <= 1'b1;
`ifdef PIPELINE_DUMP_FRAMING_EN
                        csum_q  <= '0;
                        state_q <= ST_HDR;
`else
                        state_q <= ST_LOAD_PC;
`endif
                    end
                end
`ifdef PIPELINE_DUMP_FRAMING_EN
                ST_HDR: begin
                    if (ser_last_c) begin
                        state_q <= ST_LOAD_PC;
                    end
                end
                ST_CSUM: begin
                    if (ser_last_c) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
`endif
                ST_LOAD_PC: begin
                    src_q   <= SRC_PC;
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
`ifdef PIPELINE_DUMP_FRAMING_EN
                    if (tx_valid && i_tx_ready) begin
                        csum_q <= csum_q ^ tx_byte;
                    end
`endif
                    if (ser_last_c) begin
                        case (src_q)
                            SRC_PC: begin
                                reg_addr_q <= '0;
                                state_q    <= ST_RD_REG;
                            end
                            SRC_REG: begin
                                if (reg_addr_q == LAST_REG) begin
                                    mem_addr_q <= '0;
                                    mem_rd_q   <= 1'b1;
                                    state_q    <= ST_RD_MEM;
                                end else begin
                                    reg_addr_q <= reg_addr_q + REG_SZ'(1);
                                    state_q    <= ST_RD_REG;
                                end
                            end
                            default: begin
                                if (mem_addr_q == LAST_MEM) begin
`ifdef PIPELINE_DUMP_FRAMING_EN
                                    state_q <= ST_CSUM;
`else
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_DONE;
`endif
                                end else begin
                                    mem_addr_q <= mem_addr_q + MEM_SZ'(1);
                                    mem_rd_q   <= 1'b1;
                                    state_q    <= ST_RD_MEM;
                                end
                            end
                        endcase
                    end
                end
                ST_RD_REG: begin
                    src_q   <= SRC_REG;
                    state_q <= ST_WAIT_REG;
                end
                ST_WAIT_REG: begin
                    state_q <= ST_SEND;
                end
                ST_RD_MEM: begin
                    mem_rd_q <= 1'b0;
                    src_q    <= SRC_MEM;
                    state_q  <= ST_WAIT_MEM;
                end
                ST_WAIT_MEM: begin
                    state_q <= ST_SEND;
                end
                ST_DONE: begin
                    if (!i_halt) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    dump_word_serializer #(
        .DATA_SZ (DATA_SZ)
    ) u_ser (
        .clk_i      (i_clk),
        .rst_ni     (i_reset_n),
        .load_i     (ser_load_c),
        .one_byte_i (ser_one_c),
        .word_i     (ser_word_c),
        .ready_i    (i_tx_ready),
        .byte_o     (tx_byte),
        .valid_o    (tx_valid),
        .last_c_o   (ser_last_c)
    );

endmodule

// File: tb/tb_pipeline_dump.sv
// Scoreboard bench for pipeline_dump: a reference model queues the expected
// byte stream, a negedge monitor pops and compares each accepted byte.
module tb_pipeline_dump;

    localparam int MEM_WORDS = 16;
`ifdef PIPELINE_DUMP_FRAMING_EN
    localparam int TOTAL = (1 + 32 + MEM_WORDS) * 4 + 2;
`else
    localparam int TOTAL = (1 + 32 + MEM_WORDS) * 4;
`endif
    localparam int EXP_CYC = TOTAL + 2 * (32 + MEM_WORDS) + 1;
    localparam int LIMIT   = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic [31:0] pc_in;
    logic [4:0]  o_reg_addr;
    logic [31:0] reg_data;
    logic [9:0]  o_mem_addr;
    logic        o_mem_rd;
    logic [31:0] mem_data;
    logic [7:0]  o_tx_byte;
    logic        o_tx_valid;
    logic        tx_ready;
    logic        o_busy;
    logic        o_done;

    logic [31:0] regs_m [32];
    logic [31:0] mem_m  [MEM_WORDS];
    logic [7:0]  exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int byte_cnt, busy_cycles, mem_rd_cnt;
    bit rand_ready = 1'b0;
    bit have_held  = 1'b0;
    logic [7:0] held_byte;
    logic [4:0] last_reg = '0;

    always #5 clk = ~clk;

    pipeline_dump #(.DATA_SZ(32), .REG_SZ(5), .MEM_SZ(10), .MEM_WORDS(MEM_WORDS)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_halt     (halt),
        .i_pc       (pc_in),
        .o_reg_addr (o_reg_addr),
        .i_reg_data (reg_data),
        .o_mem_addr (o_mem_addr),
        .o_mem_rd   (o_mem_rd),
        .i_mem_data (mem_data),
        .o_tx_byte  (o_tx_byte),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    // Synchronous-read debug ports; memory data is garbage unless strobed.
    always @(posedge clk) begin
        reg_data <= regs_m[o_reg_addr];
        mem_data <= o_mem_rd ? mem_m[o_mem_addr[3:0]] : 32'hDEAD_BEEF;
    end

    // Transmitter ready, updated just after each rising edge.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame = [hdr] PC, regs, mem words LSB first [, xor].
    task automatic build_expected(input logic [31:0] pc);
        logic [31:0] words [$];
        logic [7:0]  b;
        logic [7:0]  x;
        x = 8'h00;
        exp_q.delete();
        words.push_back(pc);
        for (int k = 0; k < 32; k++) words.push_back(regs_m[k]);
        for (int a = 0; a < MEM_WORDS; a++) words.push_back(mem_m[a]);
`ifdef PIPELINE_DUMP_FRAMING_EN
        exp_q.push_back(8'hA5);
`endif
        foreach (words[i]) begin
            for (int j = 0; j < 4; j++) begin
                b = 8'(words[i] >> (8 * j));
                x = x ^ b;
                exp_q.push_back(b);
            end
        end
`ifdef PIPELINE_DUMP_FRAMING_EN
        exp_q.push_back(x);
`endif
    endtask

    // Monitor: byte scoreboard, hold stability, read-port sequencing.
    always @(negedge clk) begin
        if (!rst_n) begin
            have_held = 1'b0;
            last_reg  = '0;
        end else begin
            if (o_busy) busy_cycles++;
            if (o_mem_rd) begin
                check("mem_rd_addr", 32'(o_mem_addr), 32'(mem_rd_cnt));
                mem_rd_cnt++;
            end
            if (o_reg_addr != last_reg) begin
                check("reg_addr_step", 32'(o_reg_addr), 32'(5'(last_reg + 5'd1)));
                last_reg = o_reg_addr;
            end
            if (have_held && o_tx_valid) check("byte_stable", 32'(o_tx_byte), 32'(held_byte));
            have_held = o_tx_valid && !tx_ready;
            held_byte = o_tx_byte;
            if (o_tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("unexpected_byte", 32'(o_tx_byte), 32'hFFFF_FFFF);
                else check("tx_byte", 32'(o_tx_byte), 32'(exp_q.pop_front()));
                byte_cnt++;
            end
        end
    end

    task automatic start_dump(input logic [31:0] pc);
        pc_in = pc;
        build_expected(pc);
        busy_cycles = 0;
        mem_rd_cnt  = 0;
        byte_cnt    = 0;
        @(negedge clk);
        halt = 1'b1;
    endtask

    task automatic wait_bytes(input int n);
        int c = 0;
        while (byte_cnt < n && c < LIMIT) begin @(negedge clk); c++; end
        check("byte_wait_timeout", 32'(byte_cnt >= n), 32'd1);
    endtask

    task automatic wait_end();
        int c = 0;
        while (!o_busy && c < 50) begin @(negedge clk); c++; end
        while (o_busy && c < LIMIT) begin @(negedge clk); c++; end
        check("dump_finishes", 32'(o_busy), 32'd0);
    endtask

    task automatic end_checks(input bit check_cyc);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("byte_count", 32'(byte_cnt), 32'(TOTAL));
        check("mem_rd_count", 32'(mem_rd_cnt), 32'(MEM_WORDS));
        check("done_high", 32'(o_done), 32'd1);
        check("last_reg_addr", 32'(o_reg_addr), 32'd31);
        check("valid_low_at_done", 32'(o_tx_valid), 32'd0);
        if (check_cyc) check("busy_cycles", 32'(busy_cycles), 32'(EXP_CYC));
    endtask

    task automatic randomize_data();
        for (int k = 0; k < 32; k++) regs_m[k] = $urandom;
        for (int a = 0; a < MEM_WORDS; a++) mem_m[a] = $urandom;
    endtask

    initial begin
        rst_n = 1'b0;
        halt  = 1'b0;
        pc_in = '0;
        for (int k = 0; k < 32; k++) regs_m[k] = 32'(k);
        for (int a = 0; a < MEM_WORDS; a++) mem_m[a] = 32'h1000 + 32'(a);
        #3;
        check("rst_valid", 32'(o_tx_valid), 32'd0);
        check("rst_byte", 32'(o_tx_byte), 32'd0);
        check("rst_reg_addr", 32'(o_reg_addr), 32'd0);
        check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        check("rst_mem_rd", 32'(o_mem_rd), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed pattern, ready tied high, exact cycle count.
        start_dump(32'h0000_0010);
        wait_end();
        end_checks(1'b1);
        halt = 1'b0;
        @(negedge clk);
        check("done_clears", 32'(o_done), 32'd0);

        // Random data with ~50% ready duty.
        rand_ready = 1'b1;
        randomize_data();
        start_dump($urandom);
        wait_end();
        end_checks(1'b0);
        halt = 1'b0;
        @(negedge clk);

        // Reset mid-dump, then a complete restart from the PC.
        rand_ready = 1'b0;
        start_dump(32'h0000_0010);
        wait_bytes(50);
        @(posedge clk);
        #2 rst_n = 1'b0;
        halt = 1'b0;
        #1;
        check("rst_mid_valid", 32'(o_tx_valid), 32'd0);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_dump(32'hCAFE_0040);
        wait_end();
        end_checks(1'b1);
        halt = 1'b0;
        @(negedge clk);

        // Halt toggled mid-dump: no restart, done held while halt is high.
        rand_ready = 1'b1;
        randomize_data();
        start_dump($urandom);
        wait_bytes(30);
        @(negedge clk) halt = 1'b0;
        repeat (2) @(negedge clk);
        halt = 1'b1;
        wait_end();
        end_checks(1'b0);
        repeat (3) @(negedge clk);
        check("done_held", 32'(o_done), 32'd1);
        halt = 1'b0;
        @(negedge clk);
        check("done_after_halt_low", 32'(o_done), 32'd0);

        // Halt falls mid-dump and stays low: DONE exits after one cycle.
        start_dump($urandom);
        wait_bytes(20);
        @(negedge clk) halt = 1'b0;
        wait_end();
        end_checks(1'b0);
        @(negedge clk);
        check("done_pulse_only", 32'(o_done), 32'd0);
        check("idle_not_busy", 32'(o_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_dump.md
Name: pipeline_dump

Overview:
- Read-back counterpart to the instruction loader: once the pipeline halts, this block reads final architectural state (PC, register file, first MEM_WORDS data-memory words) and serialises it as a byte stream to the UART transmitter.
- Sits between pipeline debug read ports and the TX byte interface.
- Starts on the rising edge of the pipeline halt flag.
- Fixed frame order, each word LSB byte first: PC, regs 0..31, mem 0..MEM_WORDS-1.

Parameters:
- DATA_SZ, 32, width of PC / register / memory word (must be a multiple of 8)
- REG_SZ, 5, register-file address width (32 registers)
- MEM_SZ, 10, data-memory word address width
- MEM_WORDS, 16, number of memory words dumped (1..2**MEM_SZ)

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_halt  in  1  pipeline halt flag (level); dump starts on its rising edge
- i_pc  in  DATA_SZ  current PC, sampled at start
- o_reg_addr  out  REG_SZ  register-file debug read address
- i_reg_data  in  DATA_SZ  register read data, valid 1 cycle after address
- o_mem_addr  out  MEM_SZ  data-memory debug read address
- o_mem_rd  out  1  data-memory read strobe
- i_mem_data  in  DATA_SZ  memory read data, valid 1 cycle after o_mem_rd
- o_tx_byte  out  8  byte to transmitter
- o_tx_valid  out  1  byte valid
- i_tx_ready  in  1  transmitter accepts byte
- o_busy  out  1  dump in progress
- o_done  out  1  dump complete; held until i_halt falls

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; o_tx_valid=0, o_tx_byte=0, o_reg_addr=0, o_mem_addr=0, o_mem_rd=0, o_busy=0, o_done=0; halt edge register=0. Takes effect immediately, including mid-dump; no partial byte completes.
- Halt edge detect: registered copy of i_halt; start = i_halt & ~halt_q. Only accepted in IDLE.
- States:
  - IDLE --start--> LOAD_PC.
  - LOAD_PC: capture i_pc into shift register; byte count=0 --> SEND.
  - SEND: present shift[7:0] on o_tx_byte with o_tx_valid=1.
    - A transfer occurs on a clock edge where o_tx_valid & i_tx_ready are both 1; on transfer, shift right 8 and increment byte count.
    - o_tx_byte stays stable while valid and not ready.
    - After DATA_SZ/8 transfers the next state is chosen by the source just finished:
      - PC -> RD_REG with index 0.
      - reg idx<31 -> RD_REG idx+1; reg 31 -> RD_MEM with addr 0.
      - mem addr<MEM_WORDS-1 -> RD_MEM addr+1; last mem word -> DONE.
  - RD_REG: drive o_reg_addr=idx --> WAIT_REG (1 cycle) --> capture i_reg_data --> SEND.
  - RD_MEM: drive o_mem_addr, pulse o_mem_rd for 1 cycle --> WAIT_MEM --> capture i_mem_data --> SEND.
  - DONE: o_done=1, o_busy=0; to IDLE when i_halt=0.
- o_busy=1 in every state except IDLE and DONE. o_tx_valid=1 only in SEND.
- Output counts:
  - Total bytes = (1+32+MEM_WORDS)*DATA_SZ/8; 196 with defaults.
  - Minimum dump time with ready tied high is bytes + 2 cycles per read word + 1 cycle.
- Boundaries:
  - i_halt falling mid-dump is ignored; the dump completes and DONE exits immediately.
  - A new rising edge while busy is ignored.
  - Index counters never wrap past their last value.
  - i_tx_ready high while o_tx_valid=0 has no effect.

Optional Feature:
- Macro: PIPELINE_DUMP_FRAMING_EN.
- Defined:
  - A header byte 0xA5 is sent before the PC.
  - After the last memory byte, a checksum byte is sent: XOR of all payload bytes, header excluded.
  - Both bytes use the same handshake, via states HDR and CSUM.
  - Total 198 bytes with defaults.
- Undefined: no header/checksum logic or states; raw payload only.

Decomposition:
- Package pipeline_dump_pkg holds:
  - state enum codes;
  - DUMP_HDR=8'hA5;
  - NUM_REGS=32;
  - byte-per-word constant.
- Sub-module: dump_word_serializer. Loads a DATA_SZ word, emits bytes LSB-first over valid/ready, and pulses last-byte-done. The top-level FSM sequences sources and addresses.

Test Plan:
- Ready tied high; PC=0x0000_0010, reg[k]=k, mem[a]=0x1000+a; raise i_halt -> bytes 10 00 00 00, then 00 00 00 00, 01 00 00 00 ... 1F 00 00 00, then 00 10 00 00 ... 0F 10 00 00; 196 bytes; o_done=1.
- Random ready with ~50% duty -> identical byte sequence; o_tx_byte never changes while valid & !ready.
- Check read timing: o_reg_addr steps 0..31, o_mem_rd pulses 16 times at addresses 0..15, and each captured word equals the model.
- Assert i_reset_n=0 after byte 50, release, raise i_halt again -> o_tx_valid drops at once; full 196-byte dump restarts from the PC.
- i_halt toggled low and high mid-dump -> no restart; o_done rises at byte 196 and clears the cycle after i_halt=0; a fresh edge starts a new dump.
- With PIPELINE_DUMP_FRAMING_EN, defaults and data as in the first scenario -> first byte A5, last byte is the XOR of the 196 payload bytes, 198 total.
